// File: rtl/note_sound_pkg.sv
// note_sound_pkg: shared types and voice tables for note_sound_scheduler.
// Half-periods are in clk_50 cycles (50 MHz) for a square-wave generator.
package note_sound_pkg;

  localparam int HP_W = 18;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    LANE0 = 3'd1,
    LANE1 = 3'd2,
    LANE2 = 3'd3,
    HIT   = 3'd4,
    MISS  = 3'd5
  } voice_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [HP_W-1:0] HP_C5 = 18'd47801;
  localparam logic [HP_W-1:0] HP_E5 = 18'd37936;
  localparam logic [HP_W-1:0] HP_G5 = 18'd31888;
  localparam logic [HP_W-1:0] HP_C6 = 18'd23878;
  localparam logic [HP_W-1:0] HP_G3 = 18'd127551;

  typedef struct packed {
    logic [HP_W-1:0] half_period;
    logic            last_step;
  } voice_step_t;

  // Step table: lanes are single-step, hit and miss have two steps.
  function automatic voice_step_t voice_step(input voice_e v, input logic step);
    voice_step_t r;
    r.half_period = '0;
    r.last_step   = 1'b1;
    case (v)
      LANE0: r.half_period = HP_C5;
      LANE1: r.half_period = HP_E5;
      LANE2: r.half_period = HP_G5;
      HIT: begin
        r.half_period = step ? HP_C6 : HP_G5;
        r.last_step   = step;
      end
      MISS: begin
        r.half_period = HP_G3;
        r.last_step   = step;
      end
      default: r.half_period = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_lane(input voice_e v);
    return (v == LANE0) || (v == LANE1) || (v == LANE2);
  endfunction

endpackage

// File: rtl/note_sound_scheduler_sync.sv
// sync_edge_det: 2-flop synchronizer for an asynchronous level plus a
// delayed copy, producing the synchronized level and a rising-edge pulse.
module sync_edge_det (
  input  logic clk_50,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s2_dly_q;

  // Synchronizer chain and one-cycle delayed copy for edge detection.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s2_dly_q <= 1'b0;
    end else begin
      s1_q     <= async_i;
      s2_q     <= s1_q;
      s2_dly_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s2_dly_q;

endmodule

// File: rtl/note_sound_scheduler.sv
// note_sound_scheduler: arbitrates five tone requesters (three lanes, hit,
// miss) onto one square-wave generator, sequencing each grant as
// play-then-gap.
// Optional build macro NOTE_SUSTAIN_EN: a lane voice keeps playing while its
// button stays held, up to 4*NOTE_CYCLES.
//
// state | meaning
// IDLE  | waiting for a pending request with enable high
// PLAY  | tone generator running, counting note steps
// GAP   | silent spacing after a grant, voice still reported
module note_sound_scheduler
  import note_sound_pkg::*;
#(
  parameter int NOTE_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 250000,
  parameter int DIV_W       = 18,
  parameter int CNT_W       = 25
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       lane_req,
  input  logic             hit_evt,
  input  logic             miss_evt,
  output logic [DIV_W-1:0] tone_half_period,
  output logic             tone_valid,
  output logic             tone_load,
  output logic [2:0]       active_voice,
  output logic             busy
);

  // Source index: 0..2 lanes, 3 hit, 4 miss.
  localparam int SRC_HIT  = 3;
  localparam int SRC_MISS = 4;

  if (NOTE_CYCLES < 1 || longint'(NOTE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_note
    $error("NOTE_CYCLES does not fit in CNT_W");
  end
  if (GAP_CYCLES < 1 || longint'(GAP_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_gap
    $error("GAP_CYCLES does not fit in CNT_W");
  end
`ifdef NOTE_SUSTAIN_EN
  if (4 * longint'(NOTE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_sustain
    $error("4*NOTE_CYCLES does not fit in CNT_W");
  end
  localparam logic [CNT_W-1:0] SUST_LAST = CNT_W'(4 * NOTE_CYCLES - 1);
`endif

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  logic [4:0] src_raw;
  logic [4:0] src_lvl;
  logic [4:0] src_rise;

  assign src_raw = {miss_evt, hit_evt, lane_req};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    sync_edge_det u_sync (
      .clk_50  (clk_50),
      .rst     (rst),
      .async_i (src_raw[i]),
      .level_o (src_lvl[i]),
      .rise_o  (src_rise[i])
    );
  end

  state_e            state_q, state_d;
  voice_e            voice_q, voice_d;
  logic              step_q, step_d;
  logic [1:0]        rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        pend_q, pend_d;
  logic [4:0]        clr;
  logic              start_step;
  logic [DIV_W-1:0]  tone_hp_q, tone_hp_d;
  logic              valid_q, valid_d;
  logic              load_q, load_d;

  voice_e            gnt_voice;
  logic [4:0]        gnt_mask;
  logic [1:0]        gnt_rr;
  logic              play_done;
  voice_step_t       cur_step;
  voice_step_t       next_step;

  assign cur_step  = voice_step(voice_q, step_q);
  assign next_step = voice_step(voice_d, step_d);

  // Set beats clear: an edge arriving on the grant cycle is replayed later.
  assign pend_d = (pend_q & ~clr) | src_rise;

  // Pending request bits.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // Arbitration: hit, then miss, then lanes round-robin from rr_q.
  always_comb begin
    int j;
    j         = 0;
    gnt_voice = NONE;
    gnt_mask  = '0;
    gnt_rr    = rr_q;
    for (int k = 2; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= 3) j = j - 3;
      if (pend_q[j]) begin
        gnt_voice = voice_e'(3'(j + 1));
        gnt_mask  = 5'(1 << j);
        gnt_rr    = (j == 2) ? 2'd0 : 2'(j + 1);
      end
    end
    if (pend_q[SRC_MISS]) begin
      gnt_voice = MISS;
      gnt_mask  = 5'b10000;
      gnt_rr    = rr_q;
    end
    if (pend_q[SRC_HIT]) begin
      gnt_voice = HIT;
      gnt_mask  = 5'b01000;
      gnt_rr    = rr_q;
    end
  end

`ifdef NOTE_SUSTAIN_EN
  logic lane_lvl;
  logic unused_lvl;
  assign unused_lvl = ^src_lvl[4:3];

  // End of a note step; a held lane extends its note up to 4 steps long.
  always_comb begin
    lane_lvl = 1'b0;
    case (voice_q)
      LANE0:   lane_lvl = src_lvl[0];
      LANE1:   lane_lvl = src_lvl[1];
      LANE2:   lane_lvl = src_lvl[2];
      default: lane_lvl = 1'b0;
    endcase
    play_done = (cnt_q == NOTE_LAST);
    if (is_lane(voice_q))
      play_done = (cnt_q >= NOTE_LAST) && (!lane_lvl || (cnt_q == SUST_LAST));
  end
`else
  logic unused_lvl;
  assign unused_lvl = ^src_lvl;

  // End of a note step.
  always_comb begin
    play_done = (cnt_q == NOTE_LAST);
  end
`endif

  logic unused_step_bits;
  assign unused_step_bits = ^{cur_step.half_period, next_step.last_step};

  // FSM state and sequencing registers.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      voice_q <= NONE;
      step_q  <= 1'b0;
      rr_q    <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      voice_q <= voice_d;
      step_q  <= step_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: grant, step advance, gap timing.
  always_comb begin
    state_d    = state_q;
    voice_d    = voice_q;
    step_d     = step_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q + 1'b1;
    clr        = '0;
    start_step = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (enable && (gnt_voice != NONE)) begin
          state_d    = PLAY;
          voice_d    = gnt_voice;
          step_d     = 1'b0;
          cnt_d      = '0;
          clr        = gnt_mask;
          rr_d       = gnt_rr;
          start_step = 1'b1;
        end
      end
      PLAY: begin
        if (play_done) begin
          cnt_d = '0;
          if (!cur_step.last_step) begin
            step_d     = 1'b1;
            start_step = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          voice_d = NONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        voice_d = NONE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values, registered so they change on the transition edge.
  always_comb begin
    valid_d   = (state_d == PLAY);
    load_d    = start_step;
    tone_hp_d = tone_hp_q;
    if (start_step) tone_hp_d = DIV_W'(next_step.half_period);
  end

  // Output registers; async reset drops tone_valid immediately.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      tone_hp_q <= '0;
      valid_q   <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      tone_hp_q <= tone_hp_d;
      valid_q   <= valid_d;
      load_q    <= load_d;
    end
  end

  assign tone_half_period = tone_hp_q;
  assign tone_valid       = valid_q;
  assign tone_load        = load_q;
  assign active_voice     = voice_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_note_sound_scheduler.sv
// Testbench for note_sound_scheduler with NOTE_CYCLES=100, GAP_CYCLES=10.
module tb_note_sound_scheduler;

  localparam int NOTE = 100;
  localparam int GAP  = 10;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        enable;
  logic [2:0]  lane_req;
  logic        hit_evt;
  logic        miss_evt;
  logic [17:0] tone_half_period;
  logic        tone_valid;
  logic        tone_load;
  logic [2:0]  active_voice;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [20:0] loads[$];
  logic [20:0] exp_q[$];

  // Reference model state: pending set (0..2 lanes, 3 hit, 4 miss), rr lane.
  bit [4:0] m_pend;
  int       m_rr;

  always #10 clk_50 = ~clk_50;

  note_sound_scheduler #(
    .NOTE_CYCLES (NOTE),
    .GAP_CYCLES  (GAP),
    .DIV_W       (18),
    .CNT_W       (25)
  ) dut (
    .clk_50           (clk_50),
    .rst              (rst),
    .enable           (enable),
    .lane_req         (lane_req),
    .hit_evt          (hit_evt),
    .miss_evt         (miss_evt),
    .tone_half_period (tone_half_period),
    .tone_valid       (tone_valid),
    .tone_load        (tone_load),
    .active_voice     (active_voice),
    .busy             (busy)
  );

  always @(negedge clk_50)
    if (!rst && tone_load) loads.push_back({active_voice, tone_half_period});

  // Next granted voice: hit, miss, else first pending lane from m_rr.
  function automatic int model_pick();
    int l;
    if (m_pend[3]) begin m_pend[3] = 1'b0; return 4; end
    if (m_pend[4]) begin m_pend[4] = 1'b0; return 5; end
    for (int k = 0; k < 3; k++) begin
      l = (m_rr + k) % 3;
      if (m_pend[l]) begin
        m_pend[l] = 1'b0;
        m_rr = (l + 1) % 3;
        return l + 1;
      end
    end
    return 0;
  endfunction

  function automatic void push_steps(input int v);
    case (v)
      1: exp_q.push_back({3'd1, 18'd47801});
      2: exp_q.push_back({3'd2, 18'd37936});
      3: exp_q.push_back({3'd3, 18'd31888});
      4: begin exp_q.push_back({3'd4, 18'd31888}); exp_q.push_back({3'd4, 18'd23878}); end
      5: begin exp_q.push_back({3'd5, 18'd127551}); exp_q.push_back({3'd5, 18'd127551}); end
      default: ;
    endcase
  endfunction

  function automatic void drain_model();
    int v;
    v = model_pick();
    while (v != 0) begin
      push_steps(v);
      v = model_pick();
    end
  endfunction

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b1; lane_req = 3'b000; hit_evt = 1'b0; miss_evt = 1'b0;
    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    @(negedge clk_50);
    loads.delete(); exp_q.delete();
    m_pend = '0; m_rr = 0;
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk_50);
    lane_req = m[2:0]; hit_evt = m[3]; miss_evt = m[4];
    repeat (3) @(negedge clk_50);
    lane_req = 3'b000; hit_evt = 1'b0; miss_evt = 1'b0;
  endtask

  task automatic wait_quiet(output bit timed_out);
    int low;
    low = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk_50);
      if (busy) low = 0; else low++;
      if (low >= 4) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic wait_first_load(output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (loads.size() > 0) begin timed_out = 1'b0; break; end
      @(negedge clk_50);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; lane_req = 3'b000; hit_evt = 1'b0; miss_evt = 1'b0;
    #5;
    n_checks++; if (tone_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", tone_valid); else n_pass++;
    n_checks++; if (tone_load !== 1'b0) $display("FAIL reset_load: got %b want 0", tone_load); else n_pass++;
    n_checks++; if (tone_half_period !== 18'd0) $display("FAIL reset_hp: got %0d want 0", tone_half_period); else n_pass++;
    n_checks++; if (active_voice !== 3'd0) $display("FAIL reset_voice: got %0d want 0", active_voice); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    apply_reset();
  endtask

  task automatic test_single_lane();
    int t_fall, t_idle, early;
    apply_reset();
    t_fall = -1; t_idle = -1; early = 0;
    lane_req = 3'b001;
    for (int e = 0; e < 200; e++) begin
      @(posedge clk_50); #1;
      if (e == 5) lane_req = 3'b000;
      if (e < 3 && (tone_valid || tone_load)) early++;
      if (e == 3) begin
        n_checks++; if (tone_valid !== 1'b1) $display("FAIL lane0_valid_e3: got %b want 1", tone_valid); else n_pass++;
        n_checks++; if (tone_load !== 1'b1) $display("FAIL lane0_load_e3: got %b want 1", tone_load); else n_pass++;
        n_checks++; if (tone_half_period !== 18'd47801) $display("FAIL lane0_hp_e3: got %0d want 47801", tone_half_period); else n_pass++;
        n_checks++; if (active_voice !== 3'd1) $display("FAIL lane0_voice_e3: got %0d want 1", active_voice); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL lane0_busy_e3: got %b want 1", busy); else n_pass++;
      end
      if (e == 4) begin
        n_checks++; if (tone_load !== 1'b0) $display("FAIL lane0_load_e4: got %b want 0", tone_load); else n_pass++;
      end
      if (e > 3 && t_fall < 0 && !tone_valid) t_fall = e;
      if (e > 3 && t_idle < 0 && active_voice == 3'd0) t_idle = e;
    end
    @(negedge clk_50);
    n_checks++; if (early !== 0) $display("FAIL lane0_early: got %0d early cycles want 0", early); else n_pass++;
    n_checks++; if (t_fall !== 103) $display("FAIL lane0_valid_fall: got edge %0d want 103", t_fall); else n_pass++;
    n_checks++; if (t_idle !== 113) $display("FAIL lane0_voice_clear: got edge %0d want 113", t_idle); else n_pass++;
  endtask

  task automatic test_same_cycle();
    bit to;
    apply_reset();
    press(5'b01111);
    m_pend = 5'b01111;
    drain_model();
    wait_quiet(to);
    n_checks++; if (to !== 1'b0) $display("FAIL same_cycle_timeout: got busy want idle"); else n_pass++;
    n_checks++; if (loads.size() !== exp_q.size()) $display("FAIL same_cycle_count: got %0d want %0d", loads.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < loads.size(); i++) begin
      n_checks++;
      if (loads[i] !== exp_q[i])
        $display("FAIL same_cycle_load%0d: got v%0d/%0d want v%0d/%0d", i, loads[i][20:18], loads[i][17:0], exp_q[i][20:18], exp_q[i][17:0]);
      else n_pass++;
    end
  endtask

  task automatic test_replay();
    bit to;
    apply_reset();
    press(5'b00010);
    m_pend = 5'b00010;
    push_steps(model_pick());
    wait_first_load(to);
    n_checks++; if (to !== 1'b0) $display("FAIL replay_first_timeout: got no load want load"); else n_pass++;
    repeat (30) @(negedge clk_50);
    press(5'b00010);
    m_pend = m_pend | 5'b00010;
    drain_model();
    wait_quiet(to);
    repeat (300) @(negedge clk_50);
    n_checks++; if (to !== 1'b0) $display("FAIL replay_timeout: got busy want idle"); else n_pass++;
    n_checks++; if (loads.size() !== exp_q.size()) $display("FAIL replay_count: got %0d want %0d", loads.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < loads.size(); i++) begin
      n_checks++;
      if (loads[i] !== exp_q[i])
        $display("FAIL replay_load%0d: got v%0d/%0d want v%0d/%0d", i, loads[i][20:18], loads[i][17:0], exp_q[i][20:18], exp_q[i][17:0]);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    int viol;
    bit to;
    apply_reset();
    enable = 1'b0;
    viol = 0;
    press(5'b00100);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk_50);
      if (tone_valid || busy) viol++;
    end
    n_checks++; if (viol !== 0) $display("FAIL enable_off_quiet: got %0d active cycles want 0", viol); else n_pass++;
    enable = 1'b1;
    @(posedge clk_50); #1;
    n_checks++; if (tone_valid !== 1'b1) $display("FAIL enable_grant_valid: got %b want 1", tone_valid); else n_pass++;
    n_checks++; if (tone_half_period !== 18'd31888) $display("FAIL enable_grant_hp: got %0d want 31888", tone_half_period); else n_pass++;
    n_checks++; if (active_voice !== 3'd3) $display("FAIL enable_grant_voice: got %0d want 3", active_voice); else n_pass++;
    wait_quiet(to);
    n_checks++; if (to !== 1'b0) $display("FAIL enable_timeout: got busy want idle"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    int act;
    apply_reset();
    press(5'b01000);
    wait_first_load(to);
    n_checks++; if (to !== 1'b0) $display("FAIL rstmid_start_timeout: got no load want load"); else n_pass++;
    repeat (50) @(negedge clk_50);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (tone_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", tone_valid); else n_pass++;
    n_checks++; if (tone_half_period !== 18'd0) $display("FAIL rstmid_hp: got %0d want 0", tone_half_period); else n_pass++;
    n_checks++; if (active_voice !== 3'd0) $display("FAIL rstmid_voice: got %0d want 0", active_voice); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk_50);
    rst = 1'b0;
    loads.delete();
    act = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_50);
      if (tone_valid) act++;
    end
    n_checks++; if (loads.size() !== 0 || act !== 0) $display("FAIL rstmid_no_regrant: got %0d loads %0d active want 0 0", loads.size(), act); else n_pass++;
  endtask

  task automatic test_sustain();
    int hold [2];
    int hi;
    hold[0] = 250; hold[1] = 1000;
    for (int h = 0; h < 2; h++) begin
      apply_reset();
      hi = 0;
      for (int c = 0; c < hold[h] + 300; c++) begin
        @(negedge clk_50);
        if (c == 0) lane_req = 3'b001;
        if (c == hold[h]) lane_req = 3'b000;
        if (tone_valid) hi++;
      end
`ifdef NOTE_SUSTAIN_EN
      if (h == 0) begin
        n_checks++; if (hi < 247 || hi > 253) $display("FAIL sustain_250: got %0d want 247..253", hi); else n_pass++;
      end else begin
        n_checks++; if (hi !== 400) $display("FAIL sustain_cap: got %0d want 400", hi); else n_pass++;
      end
`else
      n_checks++; if (hi !== NOTE) $display("FAIL no_sustain_len%0d: got %0d want %0d", hold[h], hi, NOTE); else n_pass++;
`endif
    end
  endtask

  task automatic test_random();
    bit to;
    logic [4:0] a, b;
    apply_reset();
    for (int r = 0; r < 10; r++) begin
      a = 5'($urandom_range(1, 31));
      b = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      loads.delete(); exp_q.delete();
      press(a);
      m_pend = m_pend | a;
      push_steps(model_pick());
      wait_first_load(to);
      n_checks++; if (to !== 1'b0) $display("FAIL rand%0d_start_timeout: got no load want load", r); else n_pass++;
      repeat (20) @(negedge clk_50);
      if (b != 5'd0) press(b);
      m_pend = m_pend | b;
      drain_model();
      wait_quiet(to);
      n_checks++; if (to !== 1'b0) $display("FAIL rand%0d_timeout: got busy want idle", r); else n_pass++;
      n_checks++; if (loads.size() !== exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d (a=%b b=%b)", r, loads.size(), exp_q.size(), a, b); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < loads.size(); i++) begin
        n_checks++;
        if (loads[i] !== exp_q[i])
          $display("FAIL rand%0d_load%0d: got v%0d/%0d want v%0d/%0d", r, i, loads[i][20:18], loads[i][17:0], exp_q[i][20:18], exp_q[i][17:0]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_same_cycle();
    test_replay();
    test_enable();
    test_reset_mid();
    test_sustain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
